// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its result-capture writeback stage.
package alu_pkg;

    localparam int ALU_WIDTH = 4;
    localparam int TIMER_W   = 4;

    localparam logic [2:0] MODE_NOT_A = 3'b000;
    localparam logic [2:0] MODE_ADD   = 3'b001;
    localparam logic [2:0] MODE_AND   = 3'b010;
    localparam logic [2:0] MODE_OR    = 3'b011;
    localparam logic [2:0] MODE_XOR   = 3'b100;
    localparam logic [2:0] MODE_SHL   = 3'b101;
    localparam logic [2:0] MODE_ZERO  = 3'b110;
    localparam logic [2:0] MODE_ONES  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WRITE  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/alu_result_capture_if.sv
// Bus between an ALU sequencer (master) and the result-capture stage (slave).
interface alu_result_capture_if #(
    parameter int WIDTH    = 4,
    parameter int NUM_REGS = 4
);
    localparam int AW = $clog2(NUM_REGS);

    // Handshake: a request is start=1 at a rising edge while busy=0; it is then
    // accepted and dest_addr latched. start while busy=1 is dropped. Completion is
    // a one-cycle done pulse in the cycle after the register write.
    logic             start;
    logic [AW-1:0]    dest_addr;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             busy;
    logic             done;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             carry_flag;
    logic             zero_flag;

    modport master (
        output start, dest_addr, alu_result, alu_carry, rd_addr,
        input  busy, done, rd_data, carry_flag, zero_flag
    );

    modport slave (
        input  start, dest_addr, alu_result, alu_carry, rd_addr,
        output busy, done, rd_data, carry_flag, zero_flag
    );

endinterface

// File: rtl/alu_result_capture_settle_timer.sv
// Load/decrement/zero-detect counter that times the ALU settle window.
module settle_timer
    import alu_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_result_capture.sv
// Waits out the ALU settle window after each start, then captures the ALU result
// into a small register file and updates the carry/zero flags.
module alu_result_capture
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_WIDTH,
    parameter int NUM_REGS      = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    alu_result_capture_if.slave  bus,
    output cap_state_t           dbg_state
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

    cap_state_t       state_q;
    cap_state_t       state_d;
    logic [AW-1:0]    dest_q;
    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             carry_q;
    logic             zero_q;
    logic             done_q;

    logic             accept;
    logic             write_en;
    logic             timer_dec;
    logic             timer_zero;

    settle_timer u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value (SETTLE_LOAD),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SETTLE;
            SETTLE:  if (timer_zero) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        write_en  = 1'b0;
        timer_dec = 1'b0;
        bus.busy  = 1'b1;
        case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                accept   = bus.start;
            end
            SETTLE:  timer_dec = 1'b1;
            WRITE:   write_en  = 1'b1;
            default: bus.busy  = 1'b0;
        endcase
    end

    // The ALU is sampled only on the WRITE edge; settle-window glitches never land.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dest_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done_q <= write_en;
            if (accept) begin
                dest_q <= bus.dest_addr;
            end
            if (write_en) begin
                regs[dest_q] <= bus.alu_result;
                carry_q      <= bus.alu_carry;
                zero_q       <= (bus.alu_result == '0);
            end
        end
    end

    assign bus.done       = done_q;
    assign bus.rd_data    = regs[bus.rd_addr];
    assign bus.carry_flag = carry_q;
    assign bus.zero_flag  = zero_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_result_capture.sv
// Bench for alu_result_capture: directed scenarios plus randomized traffic against a
// schedule-based reference model (write lands SETTLE_CYCLES+1 edges after acceptance).
module tb_alu_result_capture;
    import alu_pkg::*;

    localparam int W  = 4;
    localparam int NR = 4;
    localparam int SC = 3;

    logic       clock;
    logic       reset;
    cap_state_t dbg_state;
    cap_state_t dbg_state1;

    alu_result_capture_if #(.WIDTH(W), .NUM_REGS(NR)) bus ();
    alu_result_capture_if #(.WIDTH(W), .NUM_REGS(NR)) bus1 ();

    alu_result_capture #(.WIDTH(W), .NUM_REGS(NR), .SETTLE_CYCLES(SC)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    alu_result_capture #(.WIDTH(W), .NUM_REGS(NR), .SETTLE_CYCLES(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus1),
        .dbg_state (dbg_state1)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model + scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    int         edge_n  = 0;
    bit         m_pending;
    int         m_wr_edge;
    logic [1:0] m_dest;
    logic [W-1:0] m_regs [NR];
    logic       m_carry;
    logic       m_zero;
    logic       m_done;
    logic [W:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 1'b0;
        m_wr_edge = 0;
        m_dest    = '0;
        m_carry   = 1'b0;
        m_zero    = 1'b0;
        m_done    = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        exp_q.delete();
    endtask

    // Called right after each rising edge, before inputs change.
    task automatic model_edge();
        edge_n++;
        m_done = 1'b0;
        if (m_pending && edge_n == m_wr_edge) begin
            m_regs[m_dest] = bus.alu_result;
            m_carry        = bus.alu_carry;
            m_zero         = (bus.alu_result == '0);
            m_done         = 1'b1;
            m_pending      = 1'b0;
            exp_q.push_back({bus.alu_carry, bus.alu_result});
        end else if (!m_pending && bus.start) begin
            m_pending = 1'b1;
            m_wr_edge = edge_n + SC + 1;
            m_dest    = bus.dest_addr;
        end
    endtask

    task automatic check_all();
        logic [W:0] e;
        check_eq("busy", bus.busy, m_pending);
        check_eq("done", bus.done, m_done);
        check_eq("rd_data", bus.rd_data, m_regs[bus.rd_addr]);
        check_eq("carry_flag", bus.carry_flag, m_carry);
        check_eq("zero_flag", bus.zero_flag, m_zero);
        if (bus.done) begin
            check_eq("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("sb_carry", bus.carry_flag, e[W]);
                check_eq("sb_zero", bus.zero_flag, e[W-1:0] == '0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic s, input logic [1:0] d, input logic [W-1:0] r,
                         input logic c, input logic [1:0] ra);
        bus.start      = s;
        bus.dest_addr  = d;
        bus.alu_result = r;
        bus.alu_carry  = c;
        bus.rd_addr    = ra;
    endtask

    task automatic run_op(input logic [1:0] d, input logic [W-1:0] r, input logic c);
        drive(1'b1, d, r, c, d);
        tick();
        bus.start = 1'b0;
        repeat (SC + 1) tick();
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [W-1:0] exp);
        bus.rd_addr = a;
        #1;
        check_eq(tag, bus.rd_data, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dones;
        model_reset();
        drive(1'b0, 2'd0, 4'h0, 1'b0, 2'd0);
        bus1.start = 1'b0; bus1.dest_addr = '0; bus1.alu_result = '0;
        bus1.alu_carry = 1'b0; bus1.rd_addr = '0;
        reset = 1'b0;
        #12;
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_flags", {bus.carry_flag, bus.zero_flag}, 0);
        @(negedge clock);
        reset = 1'b1;

        // 1: basic capture with carry
        drive(1'b1, 2'd2, 4'hA, 1'b1, 2'd2);
        tick();
        check_eq("t1_busy_e0", bus.busy, 1);
        bus.start = 1'b0;
        repeat (SC) tick();
        check_eq("t1_busy_e3", bus.busy, 1);
        check_eq("t1_nodone_e3", bus.done, 0);
        tick();
        check_eq("t1_done", bus.done, 1);
        check_eq("t1_rd", bus.rd_data, 4'hA);
        check_eq("t1_carry", bus.carry_flag, 1);
        check_eq("t1_zero", bus.zero_flag, 0);
        tick();
        check_eq("t1_done_clr", bus.done, 0);

        // 2: zero result
        run_op(2'd1, 4'h0, 1'b0);
        check_eq("t2_zero", bus.zero_flag, 1);
        check_eq("t2_carry", bus.carry_flag, 0);
        read_check("t2_r1", 2'd1, 4'h0);
        read_check("t2_r2", 2'd2, 4'hA);
        tick();

        // 3: glitching ALU during SETTLE
        drive(1'b1, 2'd0, 4'h3, 1'b0, 2'd0);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < SC; i++) begin
            bus.alu_result = (i % 2 == 0) ? 4'hF : 4'h3;
            tick();
        end
        bus.alu_result = 4'hF;
        tick();
        check_eq("t3_rd", bus.rd_data, 4'hF);
        tick();

        // 4: start while busy dropped; start in done cycle accepted
        dones = 0;
        drive(1'b1, 2'd0, 4'h7, 1'b1, 2'd3);
        tick();
        bus.dest_addr = 2'd3;
        repeat (SC) begin tick(); dones += int'(bus.done); end
        tick();
        dones += int'(bus.done);
        check_eq("t4_one_done", dones, 1);
        check_eq("t4_r3_untouched", bus.rd_data, 4'h0);
        bus.alu_result = 4'h5;
        bus.alu_carry  = 1'b0;
        tick();
        check_eq("t4_accept_busy", bus.busy, 1);
        bus.start = 1'b0;
        repeat (SC + 1) tick();
        check_eq("t4_r3", bus.rd_data, 4'h5);

        // 5: async reset mid-SETTLE
        drive(1'b1, 2'd1, 4'h6, 1'b1, 2'd1);
        tick();
        bus.start = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_eq("t5_busy", bus.busy, 0);
        check_eq("t5_flags", {bus.carry_flag, bus.zero_flag}, 0);
        for (int a = 0; a < NR; a++) read_check("t5_regs", 2'(a), 4'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (SC + 3) tick();

        // 6: SETTLE_CYCLES=1 instance
        bus1.start = 1'b1; bus1.dest_addr = 2'd1; bus1.alu_result = 4'h9;
        bus1.alu_carry = 1'b1; bus1.rd_addr = 2'd1;
        tick();
        bus1.start = 1'b0;
        check_eq("t6_busy_e0", bus1.busy, 1);
        tick();
        check_eq("t6_nodone_e1", bus1.done, 0);
        tick();
        check_eq("t6_done_e2", bus1.done, 1);
        check_eq("t6_rd", bus1.rd_data, 4'h9);
        check_eq("t6_carry", bus1.carry_flag, 1);
        tick();
        check_eq("t6_done_clr", bus1.done, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 2) == 0), 2'($urandom_range(0, NR - 1)),
                  W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, NR - 1)));
            tick();
        end
        bus.start = 1'b0;
        repeat (SC + 2) tick();
        for (int a = 0; a < NR; a++) read_check("final_regs", 2'(a), m_regs[a]);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
